// File: rtl/qk_score_sequencer.sv
// Sequences one attention row: streams keys from the K tile buffer into dot_product
// against a held Q vector and forwards tagged scores to softmax. Optional QK_ROW_MAX_EN adds a row max.
module qk_score_sequencer #(
  parameter int TILE_K   = 16,
  parameter int IDX_W    = $clog2(TILE_K),
  parameter int SCORE_QT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_in,
  input  logic [IDX_W:0]             num_keys_in,
  output logic                       busy_out,
  output logic                       done_out,
  input  logic                       q_vld_in,
  output logic                       q_rdy_out,
  output logic                       kbuf_rd_en_out,
  output logic [IDX_W-1:0]           kbuf_rd_addr_out,
  output logic                       dp_Q_vld_out,
  output logic                       dp_K_vld_out,
  input  logic                       dp_Q_rdy_in,
  input  logic                       dp_K_rdy_in,
  input  logic                       dp_vld_in,
  output logic                       dp_rdy_out,
  input  logic [SCORE_QT-1:0]        dp_s_in,
  output logic                       score_vld_out,
  input  logic                       score_rdy_in,
  output logic [SCORE_QT-1:0]        score_out,
  output logic [IDX_W-1:0]           score_idx_out,
  output logic                       score_last_out,
`ifdef QK_ROW_MAX_EN
  output logic signed [SCORE_QT-1:0] row_max_out,
  output logic                       row_max_vld_out,
`endif
  output logic [2:0]                 dbg_state_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [IDX_W:0] TILE_K_C = (IDX_W+1)'(TILE_K);

  state_e         state_q, state_d;
  logic [IDX_W:0] n_q, n_d;
  logic [IDX_W:0] issue_q, issue_d;
  logic [IDX_W:0] ret_q, ret_d;
  logic           pend_q, pend_d;
  logic           busy, pair_hs, rd_en, score_acc;

  // Every valid/ready pair transfers on a clock edge where both are high; a valid,
  // once raised, holds its payload until that edge.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    busy      = (state_q != S_IDLE);
    pair_hs   = pend_q & dp_Q_rdy_in & dp_K_rdy_in;
    rd_en     = (state_q == S_RUN) && (issue_q < n_q) && (!pend_q || pair_hs);
    score_acc = dp_vld_in & busy & score_rdy_in;
    issue_d   = rd_en ? issue_q + 1'b1 : issue_q;
    ret_d     = score_acc ? ret_q + 1'b1 : ret_q;
    pend_d    = rd_en | (pend_q & ~pair_hs);

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          n_d     = (num_keys_in > TILE_K_C) ? TILE_K_C : num_keys_in;
          issue_d = '0;
          ret_d   = '0;
          pend_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  if (q_vld_in) state_d = (n_q == '0) ? S_DONE : S_RUN;
      S_RUN:   if (pair_hs && (issue_q == n_q)) state_d = S_DRAIN;
      S_DRAIN: if (ret_q == n_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      issue_q <= '0;
      ret_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      pend_q  <= pend_d;
    end
  end

  assign busy_out         = busy;
  assign done_out         = (state_q == S_DONE);
  assign q_rdy_out        = (state_q == S_DONE);
  assign kbuf_rd_en_out   = rd_en;
  assign kbuf_rd_addr_out = issue_q[IDX_W-1:0];
  assign dp_Q_vld_out     = pend_q;
  assign dp_K_vld_out     = pend_q;
  assign dp_rdy_out       = score_rdy_in;
  assign score_vld_out    = dp_vld_in & busy;
  assign score_out        = dp_s_in;
  assign score_idx_out    = ret_q[IDX_W-1:0];
  assign score_last_out   = (ret_q == (n_q - 1'b1));
  assign dbg_state_out    = state_q;

`ifdef QK_ROW_MAX_EN
  localparam logic signed [SCORE_QT-1:0] MOST_NEG = {1'b1, {(SCORE_QT-1){1'b0}}};

  logic signed [SCORE_QT-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if ((state_q == S_IDLE) && start_in) begin
      max_d = MOST_NEG;
    end else if (score_acc && ($signed(dp_s_in) > max_q)) begin
      max_d = $signed(dp_s_in);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) max_q <= '0;
    else      max_q <= max_d;
  end

  assign row_max_out     = max_q;
  assign row_max_vld_out = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_qk_score_sequencer.sv
// Bench for qk_score_sequencer: K buffer and dot_product models, score scoreboard,
// stall/reset/clamp rows. Row-max checks compile in with QK_ROW_MAX_EN.
module tb_qk_score_sequencer;
  localparam int TILE_K = 16;
  localparam int IDX_W  = 4;
  localparam int SW     = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start_in = 1'b0;
  logic [IDX_W:0]   num_keys_in = '0;
  logic             busy_out, done_out;
  logic             q_vld_in = 1'b0;
  logic             q_rdy_out;
  logic             kbuf_rd_en_out;
  logic [IDX_W-1:0] kbuf_rd_addr_out;
  logic             dp_Q_vld_out, dp_K_vld_out;
  logic             dp_Q_rdy_in = 1'b0;
  logic             dp_K_rdy_in = 1'b0;
  logic             dp_vld_in = 1'b0;
  logic             dp_rdy_out;
  logic [SW-1:0]    dp_s_in = '0;
  logic             score_vld_out;
  logic             score_rdy_in = 1'b0;
  logic [SW-1:0]    score_out;
  logic [IDX_W-1:0] score_idx_out;
  logic             score_last_out;
  logic [2:0]       dbg_state_out;
`ifdef QK_ROW_MAX_EN
  logic [SW-1:0]    row_max_out;
  logic             row_max_vld_out;
`endif

  qk_score_sequencer #(.TILE_K(TILE_K), .IDX_W(IDX_W), .SCORE_QT(SW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_in         (start_in),
    .num_keys_in      (num_keys_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .q_vld_in         (q_vld_in),
    .q_rdy_out        (q_rdy_out),
    .kbuf_rd_en_out   (kbuf_rd_en_out),
    .kbuf_rd_addr_out (kbuf_rd_addr_out),
    .dp_Q_vld_out     (dp_Q_vld_out),
    .dp_K_vld_out     (dp_K_vld_out),
    .dp_Q_rdy_in      (dp_Q_rdy_in),
    .dp_K_rdy_in      (dp_K_rdy_in),
    .dp_vld_in        (dp_vld_in),
    .dp_rdy_out       (dp_rdy_out),
    .dp_s_in          (dp_s_in),
    .score_vld_out    (score_vld_out),
    .score_rdy_in     (score_rdy_in),
    .score_out        (score_out),
    .score_idx_out    (score_idx_out),
    .score_last_out   (score_last_out),
`ifdef QK_ROW_MAX_EN
    .row_max_out      (row_max_out),
    .row_max_vld_out  (row_max_vld_out),
`endif
    .dbg_state_out    (dbg_state_out)
  );

  // models and scoreboard state
  logic [SW-1:0]    key_mem [TILE_K];
  logic [SW-1:0]    kdata = '0;
  logic [SW-1:0]    q_val = '0;
  logic [SW-1:0]    res_q[$];
  logic [SW-1:0]    exp_q[$];
  logic [IDX_W-1:0] exp_idx_q[$];
  logic             exp_last_q[$];
  logic [IDX_W-1:0] exp_addr_q[$];
  logic [SW-1:0]    exp_max;

  int  n_chk = 0, n_fail = 0;
  int  k_stall_left = 0, s_stall_left = 0, k_stall_arm = 0, s_stall_arm = 0;
  int  rd_cnt = 0, scr_cnt = 0, done_cnt = 0, cyc = 0, last_rd_cyc = 0;
  bit  first_hs = 0, first_score = 0, b2b = 0, force_dp_vld = 0;

  always @(posedge clk) if (kbuf_rd_en_out) kdata <= key_mem[kbuf_rd_addr_out];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_busy"},  32'(busy_out), 0);
    check_eq({pfx, "_done"},  32'(done_out), 0);
    check_eq({pfx, "_qrdy"},  32'(q_rdy_out), 0);
    check_eq({pfx, "_rden"},  32'(kbuf_rd_en_out), 0);
    check_eq({pfx, "_addr"},  32'(kbuf_rd_addr_out), 0);
    check_eq({pfx, "_qvld"},  32'(dp_Q_vld_out), 0);
    check_eq({pfx, "_kvld"},  32'(dp_K_vld_out), 0);
    check_eq({pfx, "_dprdy"}, 32'(dp_rdy_out), 0);
    check_eq({pfx, "_svld"},  32'(score_vld_out), 0);
    check_eq({pfx, "_score"}, 32'(score_out), 0);
    check_eq({pfx, "_idx"},   32'(score_idx_out), 0);
    check_eq({pfx, "_last"},  32'(score_last_out), 0);
    check_eq({pfx, "_state"}, 32'(dbg_state_out), 0);
`ifdef QK_ROW_MAX_EN
    check_eq({pfx, "_mvld"},  32'(row_max_vld_out), 0);
    check_eq({pfx, "_max"},   32'(row_max_out), 0);
`endif
  endtask

  // One cycle: drive on the falling edge, sample 1 ns later.
  task automatic step();
    @(negedge clk);
    cyc++;
    dp_K_rdy_in  = (k_stall_left == 0);
    if (k_stall_left > 0) k_stall_left--;
    score_rdy_in = (s_stall_left == 0);
    if (s_stall_left > 0) s_stall_left--;
    dp_vld_in = force_dp_vld || (res_q.size() > 0);
    dp_s_in   = (res_q.size() > 0) ? res_q[0] : '0;
    #1;
    if (dp_K_vld_out && !dp_K_rdy_in) check_eq("stall_rd", 32'(kbuf_rd_en_out), 0);
    if (kbuf_rd_en_out) begin
      if (exp_addr_q.size() > 0) check_eq("rd_addr", 32'(kbuf_rd_addr_out), 32'(exp_addr_q.pop_front()));
      if (b2b && rd_cnt > 0) check_eq("rd_gap", cyc - last_rd_cyc, 1);
      rd_cnt++;
      last_rd_cyc = cyc;
    end
    if (dp_Q_vld_out && dp_K_vld_out && dp_Q_rdy_in && dp_K_rdy_in) begin
      res_q.push_back(kdata + q_val);
      if (!first_hs) begin
        first_hs     = 1;
        k_stall_left = k_stall_arm;
      end
    end
    if (dp_vld_in && dp_rdy_out && res_q.size() > 0) void'(res_q.pop_front());
    if (score_vld_out) begin
      if (score_rdy_in) begin
        scr_cnt++;
        if (exp_q.size() > 0) begin
          check_eq("score", 32'(score_out), 32'(exp_q.pop_front()));
          check_eq("score_idx", 32'(score_idx_out), 32'(exp_idx_q.pop_front()));
          check_eq("score_last", 32'(score_last_out), 32'(exp_last_q.pop_front()));
        end
      end else begin
        check_eq("dp_rdy_stall", 32'(dp_rdy_out), 0);
        if (exp_idx_q.size() > 0) check_eq("idx_hold", 32'(score_idx_out), 32'(exp_idx_q[0]));
      end
      if (!first_score) begin
        first_score  = 1;
        s_stall_left = s_stall_arm;
      end
    end
    if (done_out) begin
      done_cnt++;
      check_eq("q_rdy_done", 32'(q_rdy_out), 1);
      check_eq("busy_done", 32'(busy_out), 1);
`ifdef QK_ROW_MAX_EN
      check_eq("row_max_vld", 32'(row_max_vld_out), 1);
      check_eq("row_max", 32'(row_max_out), 32'(exp_max));
`endif
    end else begin
      check_eq("q_rdy_low", 32'(q_rdy_out), 0);
    end
  endtask

  // Push expectations for a row of nk keys, then run it to its done pulse.
  task automatic run_row(input int nk, input int kst, input int sst, input bit start_mid, input bit preset);
    int            n_eff;
    logic [SW-1:0] s;
    bit            mid_sent;
    n_eff = (nk > TILE_K) ? TILE_K : nk;
    if (preset) begin
      key_mem[0] = 16'hFFFB;
      key_mem[1] = 16'd12;
      key_mem[2] = 16'd3;
      q_val      = '0;
    end else begin
      for (int i = 0; i < TILE_K; i++) key_mem[i] = 16'($urandom_range(0, 65535));
      q_val = 16'($urandom_range(0, 255));
    end
    exp_max = 16'h8000;
    for (int i = 0; i < n_eff; i++) begin
      s = key_mem[i] + q_val;
      exp_q.push_back(s);
      exp_idx_q.push_back(4'(i));
      exp_last_q.push_back(i == n_eff - 1);
      exp_addr_q.push_back(4'(i));
      if ($signed(s) > $signed(exp_max)) exp_max = s;
    end
    rd_cnt = 0; scr_cnt = 0; done_cnt = 0;
    first_hs = 0; first_score = 0; mid_sent = 0;
    k_stall_arm = kst; s_stall_arm = sst; b2b = (kst == 0);
    start_in    = 1'b1;
    num_keys_in = nk[IDX_W:0];
    q_vld_in    = 1'b1;
    step();
    start_in = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (done_cnt > 0) break;
      if (start_mid && !mid_sent && rd_cnt == 2) begin
        start_in    = 1'b1;
        num_keys_in = 5'd3;
        mid_sent    = 1;
      end
      step();
      start_in = 1'b0;
    end
    check_eq("row_done", done_cnt, 1);
    check_eq("rd_cnt", rd_cnt, n_eff);
    check_eq("scr_cnt", scr_cnt, n_eff);
    check_eq("exp_left", exp_q.size(), 0);
    step();
    check_eq("done_pulse", 32'(done_out), 0);
    check_eq("busy_after", 32'(busy_out), 0);
`ifdef QK_ROW_MAX_EN
    check_eq("row_max_vld_low", 32'(row_max_vld_out), 0);
    check_eq("row_max_held", 32'(row_max_out), 32'(exp_max));
`endif
    q_vld_in = 1'b0;
    step();
    check_eq("idle_busy", 32'(busy_out), 0);
    check_eq("no_extra_rd", rd_cnt, n_eff);
    check_eq("no_extra_done", done_cnt, 1);
  endtask

  task automatic reset_mid_row();
    for (int i = 0; i < TILE_K; i++) key_mem[i] = 16'($urandom_range(0, 65535));
    q_val = 16'd7;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(key_mem[i] + q_val);
      exp_idx_q.push_back(4'(i));
      exp_last_q.push_back(i == 7);
      exp_addr_q.push_back(4'(i));
    end
    rd_cnt = 0; done_cnt = 0; first_hs = 0; first_score = 0;
    k_stall_arm = 0; s_stall_arm = 0; b2b = 1;
    start_in = 1'b1; num_keys_in = 5'd8; q_vld_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (4) step();
    check_eq("mid_busy", 32'(busy_out), 1);
    @(negedge clk);
    rst = 1'b0;
    q_vld_in = 1'b0; dp_vld_in = 1'b0; dp_s_in = '0; score_rdy_in = 1'b0;
    #1;
    check_all_zero("rst_mid");
    res_q.delete(); exp_q.delete(); exp_idx_q.delete(); exp_last_q.delete(); exp_addr_q.delete();
    done_cnt = 0;
    repeat (2) step();
    check_eq("rst_no_done", done_cnt, 0);
    rst = 1'b1;
    step();
    check_eq("rst_idle", 32'(busy_out), 0);
  endtask

  initial begin
    for (int i = 0; i < TILE_K; i++) key_mem[i] = '0;
    @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    dp_Q_rdy_in = 1'b1;
    step();
    run_row(4, 0, 0, 0, 0);
    run_row(3, 2, 0, 0, 0);
    run_row(2, 0, 5, 0, 0);
    run_row(0, 0, 0, 0, 0);
    run_row(20, 0, 0, 0, 0);
    run_row(5, 0, 0, 1, 0);
    force_dp_vld = 1;
    step();
    check_eq("idle_svld", 32'(score_vld_out), 0);
    check_eq("idle_dprdy", 32'(dp_rdy_out), 1);
    force_dp_vld = 0;
    reset_mid_row();
    run_row(4, 0, 0, 0, 0);
    run_row(3, 0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qk_score_sequencer.md
Name: qk_score_sequencer

Overview:
Sequences one attention row through the dot_product datapath: holds the current Q vector, streams up to TILE_K key vectors from the K tile buffer, and issues each Q·K pair to dot_product. Scores from dot_product are passed to the softmax stage, tagged with key index and a last flag. On row completion it pops the Q vector and pulses done. Sits between the Q/K tile buffers and dot_product.

Parameters:
TILE_K, 16, max keys per tile
IDX_W, $clog2(TILE_K), key index / K buffer address width

Ports:
clk  in  1  clock
rst  in  1  async active-low reset
start_in  in  1  pulse; begin row, sampled in IDLE only
num_keys_in  in  IDX_W+1  keys this row, sampled with start_in
busy_out  out  1  high outside IDLE
done_out  out  1  one-cycle pulse at row end
q_vld_in  in  1  Q vector present at dot_product q_in
q_rdy_out  out  1  one-cycle Q pop at row end
kbuf_rd_en_out  out  1  K buffer read strobe, data valid next cycle, held until next strobe
kbuf_rd_addr_out  out  IDX_W  K buffer read address
dp_Q_vld_out  out  1  to dot_product Q_vld_in
dp_K_vld_out  out  1  to dot_product K_vld_in
dp_Q_rdy_in  in  1  from dot_product Q_rdy_out
dp_K_rdy_in  in  1  from dot_product K_rdy_out
dp_vld_in  in  1  from dot_product vld_out
dp_rdy_out  out  1  to dot_product rdy_in
dp_s_in  in  SCORE_QT  from dot_product s_out
score_vld_out  out  1  score valid to softmax
score_rdy_in  in  1  softmax ready
score_out  out  SCORE_QT  score
score_idx_out  out  IDX_W  key index of score
score_last_out  out  1  last score of row

Behaviour:
- Reset (rst low, async): state IDLE, all counters 0, every output 0.
- num_keys latched at start; 0 -> row has no keys; >TILE_K -> clamped to TILE_K.
- States: IDLE -(start_in)-> LOAD; LOAD -(q_vld_in)-> RUN (if n=0 -> DONE); RUN -(issue_cnt==n at handshake)-> DRAIN; DRAIN -(ret_cnt==n)-> DONE; DONE -> IDLE after one cycle.
- RUN:
  - kbuf_rd_en_out=1 when issue_cnt<n and (no K pending or pair handshake this cycle).
  - kbuf_rd_addr_out=issue_cnt. issue_cnt advances on strobe.
  - K pending set the cycle after strobe, cleared on handshake.
  - dp_Q_vld_out=dp_K_vld_out=K pending.
  - Handshake = both valids & dp_Q_rdy_in & dp_K_rdy_in.
  - Back-to-back: one pair per cycle when dot_product ready.
- Score path, combinational passthrough:
  - score_vld_out=dp_vld_in & busy; dp_rdy_out=score_rdy_in; score_out=dp_s_in.
  - score_idx_out=ret_cnt. score_last_out=(ret_cnt==n-1).
  - ret_cnt increments on score_vld_out & score_rdy_in.
- DONE: done_out=1, q_rdy_out=1 for exactly one cycle. busy_out drops the next cycle.
- start_in outside IDLE: ignored.
- Q vector must stay stable from LOAD through DONE; the block does not pop it earlier.
- dp_vld_in while IDLE is not forwarded (score_vld_out=0, dp_rdy_out still mirrors score_rdy_in).
- Reset mid-row: immediate return to IDLE; no done_out; Q not popped.
- Counters are IDX_W+1 bits; no wrap within a row.

Optional Feature:
QK_ROW_MAX_EN:
- Adds output row_max_out (SCORE_QT, signed) and row_max_vld_out (1).
- Running max over accepted scores; initialised to most-negative SCORE_QT at start.
- row_max_vld_out pulses with done_out, row_max_out valid that cycle and held until next start.
- For n=0, outputs most-negative value.
- Without the macro: ports absent, no max logic.

Test Plan:
- start, n=4, dot_product always ready, score_rdy_in=1 -> kbuf addrs 0,1,2,3 on consecutive cycles; 4 scores with idx 0..3; last only on idx 3; done_out and q_rdy_out one cycle each.
- n=3, dp_K_rdy_in low 2 cycles after first pair -> no new rd_en during stall; kbuf data held; addresses 0,1,2 each issued exactly once.
- n=2, score_rdy_in low 5 cycles -> dp_rdy_out low; ret_cnt frozen; done only after both accepted.
- n=0 and n=20 (TILE_K=16) -> n=0: DONE with no reads, q_rdy_out pulse. n=20: exactly 16 reads, last at idx 15.
- start_in pulsed in RUN; rst low mid-RUN -> second start ignored. Reset: all outputs 0, no done_out; next start runs cleanly.
- QK_ROW_MAX_EN, scores -5, 12, 3 -> row_max_out=12 with row_max_vld_out on done cycle.
